meas_averager: RTL and testbench

- Sits directly downstream of the conversion state machine and counter, and upstream of the SPI transmit path.
- Takes each completed conversion (count magnitude, reference sign, range) and turns it into a signed sample.
- Averages 2^L consecutive valid samples taken on the same range.
- Presents the averaged result to the SPI transmit logic with a valid/ready handshake, and flags overrun when results are lost.

---
 rtl/meas_averager.sv | 143 ++++++++++++++
 tb/tb_meas_averager.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/meas_averager.sv
// Converts each finished conversion into a signed sample and averages 2^L samples
// taken on one range, handing the average downstream over a valid/ready handshake.
module meas_averager #(
   parameter int COUNT_W      = 16,
   parameter int AVG_LOG2_MAX = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      sample_valid_i,
   input  logic [COUNT_W-1:0]        sample_count_i,
   input  logic                      sample_sign_i,
   input  logic [2:0]                sample_range_i,
   input  logic                      range_error_i,
   input  logic [2:0]                avg_log2_i,
   input  logic                      flush_i,
   output logic signed [COUNT_W:0]   result_o,
   output logic [2:0]                result_range_o,
   output logic                      result_valid_o,
   input  logic                      result_ready_i,
   output logic                      overrun_o,
   output logic [AVG_LOG2_MAX:0]     fill_o
);

   localparam int ACC_W  = COUNT_W + 1 + AVG_LOG2_MAX;
   localparam int FILL_W = AVG_LOG2_MAX + 1;

   typedef enum logic {
      EMPTY,
      FILLING
   } state_t;

   state_t                    state, state_nxt;
   logic signed [ACC_W-1:0]   acc, acc_nxt;
   logic [FILL_W-1:0]         fill, fill_nxt;
   logic [2:0]                l_win, l_win_nxt;
   logic [2:0]                range_q, range_nxt;
   logic signed [COUNT_W:0]   result_q, result_nxt;
   logic [2:0]                result_range_q, result_range_nxt;
   logic                      result_valid_q, result_valid_nxt;
   logic                      overrun_q, overrun_nxt;

   logic signed [ACC_W-1:0]   mag, s_ext, sum;
   logic [2:0]                l_req, l_use;
   logic [FILL_W-1:0]         fill_inc;
   logic                      restart, complete;

   assign mag   = ACC_W'(sample_count_i);
   assign s_ext = sample_sign_i ? -mag : mag;
   assign l_req = (int'(avg_log2_i) > AVG_LOG2_MAX) ? 3'(AVG_LOG2_MAX) : avg_log2_i;

   // A sample opens a fresh window when nothing is pending or the range moved.
   assign restart  = (state == EMPTY) || (sample_range_i != range_q);
   assign l_use    = restart ? l_req : l_win;
   assign sum      = (restart ? '0 : acc) + s_ext;
   assign fill_inc = (restart ? '0 : fill) + FILL_W'(1);

   always_comb begin
      // NOTE: every target gets a default first so no path leaves a latch behind.
      state_nxt        = state;
      acc_nxt          = acc;
      fill_nxt         = fill;
      l_win_nxt        = l_win;
      range_nxt        = range_q;
      result_nxt       = result_q;
      result_range_nxt = result_range_q;
      result_valid_nxt = result_valid_q;
      overrun_nxt      = overrun_q;
      complete         = 1'b0;

      if (flush_i) begin
         state_nxt   = EMPTY;
         acc_nxt     = '0;
         fill_nxt    = '0;
         overrun_nxt = 1'b0;
      end else if (sample_valid_i && range_error_i) begin
         state_nxt = EMPTY;
         acc_nxt   = '0;
         fill_nxt  = '0;
      end else if (sample_valid_i) begin
         l_win_nxt = l_use;
         range_nxt = sample_range_i;
         if (fill_inc == (FILL_W'(1) << l_use)) begin
            complete         = 1'b1;
            state_nxt        = EMPTY;
            acc_nxt          = '0;
            fill_nxt         = '0;
            // Arithmetic shift gives floor rounding; the average always fits COUNT_W+1.
            result_nxt       = (COUNT_W + 1)'(sum >>> l_use);
            result_range_nxt = sample_range_i;
         end else begin
            state_nxt = FILLING;
            acc_nxt   = sum;
            fill_nxt  = fill_inc;
         end
      end

      if (complete) begin
         if (result_valid_q && !result_ready_i)
            overrun_nxt = 1'b1;
         result_valid_nxt = 1'b1;
      end else if (result_valid_q && result_ready_i) begin
         result_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= EMPTY;
      end else begin
         // NOTE: state registers use non-blocking assignment so all flops update together.
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc            <= '0;
         fill           <= '0;
         l_win          <= '0;
         range_q        <= '0;
         result_q       <= '0;
         result_range_q <= '0;
         result_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         acc            <= acc_nxt;
         fill           <= fill_nxt;
         l_win          <= l_win_nxt;
         range_q        <= range_nxt;
         result_q       <= result_nxt;
         result_range_q <= result_range_nxt;
         result_valid_q <= result_valid_nxt;
         overrun_q      <= overrun_nxt;
      end
   end

   assign result_o       = result_q;
   assign result_range_o = result_range_q;
   assign result_valid_o = result_valid_q;
   assign overrun_o      = overrun_q;
   assign fill_o         = fill;

endmodule

// File: tb/tb_meas_averager.sv
// Bench for meas_averager: directed vector table, hand-written reset sequence,
// then random traffic checked against a queue-based window model.
module tb_meas_averager;

   localparam int COUNT_W      = 16;
   localparam int AVG_LOG2_MAX = 4;

   logic                      clk_i = 1'b0;
   logic                      rst_n_i;
   logic                      sample_valid_i;
   logic [COUNT_W-1:0]        sample_count_i;
   logic                      sample_sign_i;
   logic [2:0]                sample_range_i;
   logic                      range_error_i;
   logic [2:0]                avg_log2_i;
   logic                      flush_i;
   logic signed [COUNT_W:0]   result_o;
   logic [2:0]                result_range_o;
   logic                      result_valid_o;
   logic                      result_ready_i;
   logic                      overrun_o;
   logic [AVG_LOG2_MAX:0]     fill_o;

   meas_averager #(.COUNT_W(COUNT_W), .AVG_LOG2_MAX(AVG_LOG2_MAX)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .sample_valid_i (sample_valid_i),
      .sample_count_i (sample_count_i),
      .sample_sign_i  (sample_sign_i),
      .sample_range_i (sample_range_i),
      .range_error_i  (range_error_i),
      .avg_log2_i     (avg_log2_i),
      .flush_i        (flush_i),
      .result_o       (result_o),
      .result_range_o (result_range_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .overrun_o      (overrun_o),
      .fill_o         (fill_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference model: the open window is a list of sample values.
   bit use_model = 1'b0;
   int win_q[$];
   int m_l, m_rng, m_res, m_rr;
   bit m_valid, m_ov;

   function automatic int floor_div(input int a, input int l);
      int d;
      d = 1 << l;
      if (a >= 0) return a / d;
      return -((-a + d - 1) / d);
   endfunction

   task automatic model_step();
      bit done;
      int s, total;
      done = 1'b0;
      if (flush_i) begin
         win_q.delete();
         m_ov = 1'b0;
      end else if (sample_valid_i && range_error_i) begin
         win_q.delete();
      end else if (sample_valid_i) begin
         if (win_q.size() == 0 || int'(sample_range_i) != m_rng) begin
            win_q.delete();
            m_l   = (int'(avg_log2_i) > AVG_LOG2_MAX) ? AVG_LOG2_MAX : int'(avg_log2_i);
            m_rng = int'(sample_range_i);
         end
         s = sample_sign_i ? -int'(sample_count_i) : int'(sample_count_i);
         win_q.push_back(s);
         if (win_q.size() == (1 << m_l)) begin
            total = 0;
            foreach (win_q[i]) total += win_q[i];
            m_res = floor_div(total, m_l);
            m_rr  = m_rng;
            win_q.delete();
            done = 1'b1;
         end
      end
      if (done) begin
         if (m_valid && !result_ready_i) m_ov = 1'b1;
         m_valid = 1'b1;
      end else if (m_valid && result_ready_i) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      if (use_model) model_step();
      #1;
   endtask

   task automatic drive(input bit v, input int cnt, input bit sgn, input int rng,
                        input bit err, input int l, input bit fl, input bit rdy);
      sample_valid_i = v;
      sample_count_i = COUNT_W'(cnt);
      sample_sign_i  = sgn;
      sample_range_i = 3'(rng);
      range_error_i  = err;
      avg_log2_i     = 3'(l);
      flush_i        = fl;
      result_ready_i = rdy;
   endtask

   task automatic idle(input bit rdy);
      drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, rdy);
   endtask

   typedef struct {
      bit v; int cnt; bit sgn; int rng; bit err; int l; bit fl; bit rdy;
      int e_res; int e_rr; bit e_val; bit e_ov; int e_fill;
   } vec_t;

   vec_t tbl[$];

   initial begin
      idle(1'b0);
      rst_n_i = 1'b0;
      #12;
      check("reset_result", int'(result_o), 0);
      check("reset_range", int'(result_range_o), 0);
      check("reset_valid", int'(result_valid_o), 0);
      check("reset_overrun", int'(overrun_o), 0);
      check("reset_fill", int'(fill_o), 0);
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;

      //             v  cnt sg rng er l fl rd   res rr val ov fill
      tbl.push_back('{1, 100, 0, 3, 0, 2, 0, 0,    0, 0, 0, 0, 1});
      tbl.push_back('{1, 102, 0, 3, 0, 2, 0, 0,    0, 0, 0, 0, 2});
      tbl.push_back('{1, 104, 0, 3, 0, 2, 0, 0,    0, 0, 0, 0, 3});
      tbl.push_back('{1, 106, 0, 3, 0, 2, 0, 0,  103, 3, 1, 0, 0});
      tbl.push_back('{0,   0, 0, 0, 0, 0, 0, 1,  103, 3, 0, 0, 0});
      tbl.push_back('{1,   3, 1, 0, 0, 1, 0, 0,  103, 3, 0, 0, 1});
      tbl.push_back('{1,   0, 0, 0, 0, 1, 0, 0,   -2, 0, 1, 0, 0});
      tbl.push_back('{0,   0, 0, 0, 0, 0, 0, 1,   -2, 0, 0, 0, 0});
      tbl.push_back('{1,   5, 1, 5, 0, 0, 0, 0,   -5, 5, 1, 0, 0});
      tbl.push_back('{0,   0, 0, 0, 0, 0, 0, 1,   -5, 5, 0, 0, 0});
      tbl.push_back('{1,  10, 0, 1, 0, 2, 0, 0,   -5, 5, 0, 0, 1});
      tbl.push_back('{1,  20, 0, 1, 0, 2, 0, 0,   -5, 5, 0, 0, 2});
      tbl.push_back('{1,  30, 0, 2, 0, 2, 0, 0,   -5, 5, 0, 0, 1});
      tbl.push_back('{1,  40, 0, 2, 1, 2, 0, 0,   -5, 5, 0, 0, 0});
      tbl.push_back('{1,  10, 0, 4, 0, 0, 0, 0,   10, 4, 1, 0, 0});
      tbl.push_back('{1,  20, 0, 4, 0, 0, 0, 0,   20, 4, 1, 1, 0});
      tbl.push_back('{0,   0, 0, 0, 0, 0, 1, 0,   20, 4, 1, 0, 0});
      tbl.push_back('{1,  30, 0, 4, 0, 0, 0, 1,   30, 4, 1, 0, 0});
      tbl.push_back('{1,   1, 0, 4, 0, 2, 0, 1,   30, 4, 0, 0, 1});
      tbl.push_back('{1,   5, 0, 4, 0, 2, 1, 0,   30, 4, 0, 0, 0});
      tbl.push_back('{1,   1, 0, 4, 0, 2, 0, 0,   30, 4, 0, 0, 1});

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].cnt, tbl[i].sgn, tbl[i].rng, tbl[i].err,
               tbl[i].l, tbl[i].fl, tbl[i].rdy);
         tick();
         check($sformatf("row%0d_result", i), int'(result_o), tbl[i].e_res);
         check($sformatf("row%0d_range", i), int'(result_range_o), tbl[i].e_rr);
         check($sformatf("row%0d_valid", i), int'(result_valid_o), int'(tbl[i].e_val));
         check($sformatf("row%0d_overrun", i), int'(overrun_o), int'(tbl[i].e_ov));
         check($sformatf("row%0d_fill", i), int'(fill_o), tbl[i].e_fill);
      end

      // Reset in the middle of a window, with a result pending.
      drive(1'b1, 7, 1'b0, 6, 1'b0, 0, 1'b0, 1'b0);
      tick();
      check("pre_reset_valid", int'(result_valid_o), 1);
      check("pre_reset_result", int'(result_o), 7);
      drive(1'b1, 50, 1'b0, 0, 1'b0, 2, 1'b0, 1'b0);
      tick();
      tick();
      check("pre_reset_fill", int'(fill_o), 2);
      idle(1'b0);
      #2;
      rst_n_i = 1'b0;
      #1;
      check("async_reset_result", int'(result_o), 0);
      check("async_reset_range", int'(result_range_o), 0);
      check("async_reset_valid", int'(result_valid_o), 0);
      check("async_reset_fill", int'(fill_o), 0);
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, k, 1'b0, 0, 1'b0, 2, 1'b0, 1'b0);
         tick();
         if (k < 4) check($sformatf("post_reset_valid_%0d", k), int'(result_valid_o), 0);
      end
      check("post_reset_valid_4", int'(result_valid_o), 1);
      check("post_reset_result", int'(result_o), 2);
      check("post_reset_fill", int'(fill_o), 0);

      // Randomized traffic against the model.
      idle(1'b0);
      rst_n_i = 1'b0;
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      win_q.delete();
      m_l = 0; m_rng = 0; m_res = 0; m_rr = 0; m_valid = 1'b0; m_ov = 1'b0;
      use_model = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 20)),
               $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 2)),
               $urandom_range(0, 15) == 0,
               int'($urandom_range(0, 7)),
               $urandom_range(0, 31) == 0,
               $urandom_range(0, 2) == 0);
         tick();
         check($sformatf("rnd%0d_result", n), int'(result_o), m_res);
         check($sformatf("rnd%0d_range", n), int'(result_range_o), m_rr);
         check($sformatf("rnd%0d_valid", n), int'(result_valid_o), int'(m_valid));
         check($sformatf("rnd%0d_overrun", n), int'(overrun_o), int'(m_ov));
         check($sformatf("rnd%0d_fill", n), int'(fill_o), win_q.size());
      end
      use_model = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
